// File: rtl/imem_boot_ctrl_if.sv
// Host-side load handshake for imem_boot_ctrl.
// The host (master) offers one instruction word per cycle. The boot controller (slave)
// takes the word on any cycle where host_valid and host_ready are both high.
interface imem_boot_ctrl_if;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_last;
    logic        host_ready;

    modport master (
        output host_valid,
        output host_data,
        output host_last,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        input  host_last,
        output host_ready
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot/load sequencer for the Mips16 instruction memory.
// It streams host words into the IM at consecutive addresses. When loading ends it pulses
// pc_reset once, then holds rd_en high until stop.
// Optional feature macro: IMEM_NOP_PAD_EN. When it is defined, each non-zero host word is
// followed by NOP_GAP zero words. When it is undefined, the PAD path is compiled out.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned NOP_GAP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    imem_boot_ctrl_if.slave   bus,
    output logic              im_wen,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_din,
    output logic              pc_reset,
    output logic              rd_en,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [2:0] {StIdle, StLoad, StPad, StPcrst, StRun, StErr} state_e;

    state_e state_q, state_d;

    // One extra bit so the counter can sit at 2^ADDR_W ("full") without wrapping.
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              pc_reset_q, pc_reset_d;
    logic              rd_en_q, rd_en_d;
    logic              full;

`ifdef IMEM_NOP_PAD_EN
    logic [3:0] pad_q, pad_d;
    logic       last_q, last_d;
    logic       pad_req;

    assign pad_req = (bus.host_data != 16'h0000) && (NOP_GAP != 0);
`else
    logic unused_nop_gap;

    assign unused_nop_gap = ^NOP_GAP;
`endif

    assign full = addr_q[ADDR_W];

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        pc_reset_d = 1'b0;
        rd_en_d    = 1'b0;
`ifdef IMEM_NOP_PAD_EN
        pad_d      = pad_q;
        last_d     = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                addr_d = '0;
`ifdef IMEM_NOP_PAD_EN
                last_d = 1'b0;
`endif
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (bus.host_valid) begin
                    if (full) begin
                        // The accepted word has no address to go to, so it is dropped.
                        state_d = StErr;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = addr_q[ADDR_W-1:0];
                        wdata_d = bus.host_data;
                        addr_d  = addr_q + 1'b1;
`ifdef IMEM_NOP_PAD_EN
                        if (pad_req) begin
                            state_d = StPad;
                            pad_d   = 4'(NOP_GAP);
                            last_d  = bus.host_last;
                        end else if (bus.host_last) begin
                            state_d = StPcrst;
                        end
`else
                        if (bus.host_last) state_d = StPcrst;
`endif
                    end
                end
            end
`ifdef IMEM_NOP_PAD_EN
            StPad: begin
                if (full) begin
                    state_d = StErr;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q[ADDR_W-1:0];
                    wdata_d = 16'h0000;
                    addr_d  = addr_q + 1'b1;
                    pad_d   = pad_q - 4'd1;
                    if (pad_q == 4'd1) state_d = last_q ? StPcrst : StLoad;
                end
            end
`endif
            StPcrst: begin
                pc_reset_d = 1'b1;
                state_d    = StRun;
            end
            StRun: begin
                if (stop) state_d = StIdle;
                else      rd_en_d = 1'b1;
            end
            StErr: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StLoad;
                    addr_d  = '0;
`ifdef IMEM_NOP_PAD_EN
                    last_d  = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset forces all strobes low at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pc_reset_q <= 1'b0;
            rd_en_q    <= 1'b0;
`ifdef IMEM_NOP_PAD_EN
            pad_q      <= '0;
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            pc_reset_q <= pc_reset_d;
            rd_en_q    <= rd_en_d;
`ifdef IMEM_NOP_PAD_EN
            pad_q      <= pad_d;
            last_q     <= last_d;
`endif
        end
    end

    assign bus.host_ready = (state_q == StLoad);
    assign im_wen         = wen_q;
    assign im_addr        = waddr_q;
    assign im_din         = wdata_q;
    assign pc_reset       = pc_reset_q;
    assign rd_en          = rd_en_q;
    assign busy           = (state_q == StLoad) || (state_q == StPad) || (state_q == StPcrst);
    assign overflow       = (state_q == StErr);

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load sequencer for the Mips16 instruction memory. Accepts instruction words from a host over a valid/ready handshake and writes them into the IM at consecutive addresses. Optionally pads each non-NOP instruction with hazard-covering NOPs. When loading finishes, it pulses the PC reset and holds the core's read enable until told to stop. It replaces hand-driven `din`/`wen`/`pc_reset`/`rd_en` sequencing at the Mips16 top level.

## Interface
Parameters:
- `ADDR_W`, 8: IM address width; depth = 2^ADDR_W words.
- `NOP_GAP`, 3: NOP words written after each non-zero instruction; 0..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  **asynchronous, active-low** reset.
- `start`  in  1  begin a load session; sampled in IDLE and ERR only.
- `stop`  in  1  leave RUN or ERR and return to IDLE.
- `host_valid`  in  1  `host_data` is valid.
- `host_data`  in  16  instruction word.
- `host_last`  in  1  qualifies the final word of the session.
- `host_ready`  out  1  controller accepts a word this cycle.
- `im_wen`  out  1  IM write strobe.
- `im_addr`  out  ADDR_W  IM write address.
- `im_din`  out  16  IM write data.
- `pc_reset`  out  1  one-cycle PC clear to the core.
- `rd_en`  out  1  core fetch/execute enable.
- `busy`  out  1  high in LOAD, PAD or PCRST.
- `overflow`  out  1  sticky; high in ERR.

## Operation
- States: IDLE, LOAD, PAD, PCRST, RUN, ERR.
- Reset values: all outputs 0, `im_addr`=0, state IDLE, internal address counter 0, pad counter 0, last flag 0.
- **IDLE**
  - `start`=1 → LOAD.
  - Clears the address counter and last flag.
- **LOAD**
  - `host_ready`=1.
  - Transfer occurs when `host_valid`&`host_ready`. The word is written at the counter value and the counter increments.
  - After a transfer:
    - If `host_data`≠0 and `NOP_GAP`>0 → PAD, pad counter=`NOP_GAP`, last flag=`host_last`.
    - Else if `host_last` → PCRST.
    - Else stay in LOAD.
- **PAD**
  - `host_ready`=0.
  - Writes 16'h0000 at the counter each cycle, then increments the counter and decrements the pad counter.
  - When the pad counter reaches 0: → PCRST if the last flag is set, else → LOAD.
- **Full boundary**
  - Address 2^ADDR_W−1 may be written.
  - Any write (host or pad) required after that address is suppressed and the state goes to ERR. The counter never wraps.
- **PCRST**
  - `pc_reset`=1 for exactly one cycle → RUN.
- **RUN**
  - `rd_en`=1.
  - `start` is ignored.
  - `stop`=1 → IDLE with `rd_en`=0 next cycle.
- **ERR**
  - `overflow`=1, no writes.
  - `stop` → IDLE; `start` → LOAD with the counter cleared. Both clear `overflow`.
  - `start` and `stop` together: `stop` wins.
- **Reset mid-operation** (any state): return to IDLE immediately and asynchronously. Words already written stay in the IM; no further strobes are issued.

## Timing
- `im_wen`/`im_addr`/`im_din` are registered.
  - A handshake at edge N produces the write strobe during cycle N→N+1.
  - Pad writes follow on consecutive cycles with no bubble.
- `host_ready` decodes from the registered state only; it has no combinational path from `host_valid`.
- Last-word timing:
  - With padding: the last pad write occurs in cycle k, `pc_reset` is high in cycle k+1, and `rd_en` rises in cycle k+2.
  - Without padding: `pc_reset` is high in the cycle after the last host write.
- `stop` asserted in cycle j drops `rd_en` in cycle j+1.
- Throughput:
  - 1 word/cycle with no padding.
  - 1 host word per (1+`NOP_GAP`) cycles when padding.

## Configuration
- `IMEM_NOP_PAD_EN` defined: the PAD state and pad counter are present and behave as above.
- Not defined:
  - PAD is compiled out and `NOP_GAP` is ignored.
  - Every host word goes LOAD→LOAD, or LOAD→PCRST on `host_last`.
  - Host zero words are still written as ordinary data.

## Test plan
- **Padded load** (macro on, `NOP_GAP`=3): send 16'h2081, 16'h0541 (last).
  - Writes expected: addr0=2081, 1–3=0000, 4=0541, 5–7=0000.
  - Then one `pc_reset` cycle, then `rd_en`=1.
- **Zero word not padded**: send 16'h0000, 16'h1E12 (last).
  - Expected: addr0=0000, addr1=1E12, addr2–4=0000.
- **Macro off**: same stimulus as the padded load.
  - Expected: addr0=2081, addr1=0541 only; `pc_reset` the next cycle.
- **Backpressure**: hold `host_valid`=1 through PAD.
  - `host_ready`=0 for exactly 3 cycles.
  - No word is duplicated or dropped; addresses are contiguous.
- **Overflow** (`ADDR_W`=2, macro off): send 5 words.
  - Addr0–3 are written; the 5th is not.
  - `overflow`=1 and state ERR; `stop` clears it and returns to IDLE.
- **Async reset**: assert `reset`=0 mid-PAD.
  - `im_wen`, `busy` and `rd_en` drop to 0 immediately.
  - After release, `start` reloads from addr0.
